// File: rtl/dvsdclaa_nibble_seq_if.sv
// Operand/result handshake bundle for the nibble-serial CLA sequencer.
// DVSDCLAA_OVF_EN adds the signed-overflow result bit out_ovf.
interface dvsdclaa_nibble_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef DVSDCLAA_OVF_EN
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
`endif
endinterface

// File: rtl/dvsdclaa_nibble_seq.sv
// Wide adder sequencer: feeds an external 4-bit CLA one nibble per cycle.
// Define DVSDCLAA_OVF_EN to add the two's-complement overflow output.
module dvsdclaa_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dvsdclaa_nibble_seq_if.slave  io,
  output logic                  busy,
  output logic [3:0]            cla_a,
  output logic [3:0]            cla_b,
  output logic                  cla_cin,
  input  logic [3:0]            cla_s,
  input  logic                  cla_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  sum_sh_q, sum_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_sum_q, out_sum_d;
  logic          out_cout_q, out_cout_d;
  logic [W+3:0]  sum_ext;
  logic          run;
  logic          finish;

  // New CLA nibble enters at the top; works for W == 4 too.
  assign sum_ext = {cla_s, sum_sh_q};
  assign run     = (state_q == RUN);
  assign finish  = run && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_sh_d  = io.in_a;
          b_sh_d  = io.in_b;
          carry_d = io.in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_ext[W+3:4];
        carry_d  = cla_cout;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        cnt_d    = cnt_q + CW'(1);
        if (finish) begin
          state_d    = DONE;
          out_sum_d  = sum_ext[W+3:4];
          out_cout_d = cla_cout;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DVSDCLAA_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  // Overflow is latched alongside the sum so it holds the same way.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && io.in_valid) begin
      a_msb_d = io.in_a[W-1];
      b_msb_d = io.in_b[W-1];
    end
    if (finish) begin
      ovf_d = (a_msb_q == b_msb_q) && (cla_s[3] != a_msb_q);
    end
  end

  assign io.out_ovf = ovf_q;
`endif

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign io.out_sum   = out_sum_q;
  assign io.out_cout  = out_cout_q;

  assign cla_a   = run ? a_sh_q[3:0] : 4'h0;
  assign cla_b   = run ? b_sh_q[3:0] : 4'h0;
  assign cla_cin = run ? carry_q : 1'b0;

endmodule

// File: tb/tb_dvsdclaa_nibble_seq.sv
// Randomised bench for dvsdclaa_nibble_seq (NIBBLES=4) with an ideal 4-bit adder as CLA.
// Expected sums come from plain 17-bit / signed integer arithmetic.
module tb_dvsdclaa_nibble_seq;

  localparam int N = 4;
  localparam int W = 16;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [3:0] cla_a;
  logic [3:0] cla_b;
  logic       cla_cin;
  logic [3:0] cla_s;
  logic       cla_cout;

  int vectors;
  int errors;

  dvsdclaa_nibble_seq_if #(.W(W)) io ();

  dvsdclaa_nibble_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (io),
    .busy     (busy),
    .cla_a    (cla_a),
    .cla_b    (cla_b),
    .cla_cin  (cla_cin),
    .cla_s    (cla_s),
    .cla_cout (cla_cout)
  );

  assign {cla_cout, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operand pair and waits for out_valid; leaves the result undrained.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output int lat,
                        output logic [W-1:0] trace);
    int n;
    lat   = -1;
    trace = '0;
    n     = 0;
    while (!io.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_cin   = cin;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_a     = 16'($urandom);
    io.in_b     = 16'($urandom);
    io.in_cin   = 1'($urandom);
    for (int c = 1; c <= 20; c++) begin
      if (busy && !io.out_valid) trace = {cla_a, trace[W-1:4]};
      @(posedge clk);
      @(negedge clk);
      if (io.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic drain();
    io.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
               io.in_ready, io.out_valid, busy);
    end
    vectors++;
    if (io.out_sum !== 16'h0 || io.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got sum=%h cout=%b want 0000 0",
               io.out_sum, io.out_cout);
    end
    vectors++;
    if (cla_a !== 4'h0 || cla_b !== 4'h0 || cla_cin !== 1'b0) begin
      errors++;
      $display("FAIL reset_cla: got a=%h b=%h cin=%b want 0 0 0",
               cla_a, cla_b, cla_cin);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int lat;
    logic [W-1:0] tr;
    run_op(16'h1234, 16'h4321, 1'b0, lat, tr);
    vectors++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL dir_latency: got %0d want 4", lat);
    end
    vectors++;
    if (tr !== 16'h1234) begin
      errors++;
      $display("FAIL dir_cla_a_seq: got %h want 1234", tr);
    end
    vectors++;
    if (io.out_sum !== 16'h5555 || io.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL dir_sum: got %h/%b want 5555/0", io.out_sum, io.out_cout);
    end
    drain();
  endtask

  task automatic test_carry();
    logic [W-1:0] ta [4] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h8421};
    logic [W-1:0] tb [4] = '{16'h0001, 16'h0000, 16'h0000, 16'h7BDE};
    logic         tc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] es [4] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    logic         ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    logic [W-1:0] tr;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], tc[i], lat, tr);
      vectors++;
      if (lat !== 4 || io.out_sum !== es[i] || io.out_cout !== ec[i]) begin
        errors++;
        $display("FAIL carry_%0d: got lat=%0d %h/%b want lat=4 %h/%b",
                 i, lat, io.out_sum, io.out_cout, es[i], ec[i]);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int n;
    logic [W-1:0] tr;
    logic [16:0] exp2;
    run_op(16'h0F0F, 16'h0101, 1'b1, lat, tr);
    vectors++;
    if (lat !== 4 || io.out_sum !== 16'h1011 || io.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d %h/%b want lat=4 1011/0",
               lat, io.out_sum, io.out_cout);
    end
    io.in_valid = 1'b1;
    io.in_a     = 16'hBEEF;
    io.in_b     = 16'h4111;
    io.in_cin   = 1'b0;
    exp2        = 17'h0BEEF + 17'h04111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 ||
          io.out_sum !== 16'h1011 || io.out_cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b %h/%b want 1 0 1011/0",
                 i, io.out_valid, io.in_ready, io.out_sum, io.out_cout);
      end
    end
    drain();
    vectors++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 ||
        io.out_sum !== 16'h1011) begin
      errors++;
      $display("FAIL bp_idle: got rdy=%b vld=%b sum=%h want 1 0 1011",
               io.in_ready, io.out_valid, io.out_sum);
    end
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || io.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got busy=%b rdy=%b want 1 0", busy, io.in_ready);
    end
    n = 0;
    while (!io.out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 4 || io.out_sum !== exp2[15:0] || io.out_cout !== exp2[16]) begin
      errors++;
      $display("FAIL bp_second: got n=%0d %h/%b want n=4 %h/%b",
               n, io.out_sum, io.out_cout, exp2[15:0], exp2[16]);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int lat;
    int seen;
    logic [W-1:0] tr;
    run_op(16'h1234, 16'h4321, 1'b0, lat, tr);
    drain();
    io.in_valid = 1'b1;
    io.in_a     = 16'hAAAA;
    io.in_b     = 16'h1111;
    io.in_cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0 || busy !== 1'b0 ||
        io.out_sum !== 16'h0 || io.out_cout !== 1'b0 ||
        cla_a !== 4'h0 || cla_b !== 4'h0 || cla_cin !== 1'b0) begin
      errors++;
      $display("FAIL arst_values: got rdy=%b vld=%b busy=%b sum=%h cout=%b cla=%h%h%b",
               io.in_ready, io.out_valid, busy, io.out_sum, io.out_cout,
               cla_a, cla_b, cla_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (io.out_valid || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL arst_no_valid: got %0d active cycles want 0", seen);
    end
    run_op(16'h0001, 16'h0001, 1'b0, lat, tr);
    vectors++;
    if (lat !== 4 || io.out_sum !== 16'h0002 || io.out_cout !== 1'b0) begin
      errors++;
      $display("FAIL arst_next_op: got lat=%0d %h/%b want lat=4 0002/0",
               lat, io.out_sum, io.out_cout);
    end
    drain();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] tr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic cin;
    logic [16:0] full;
    int s;
    logic ovf;
    for (int i = 0; i < 40; i++) begin
      a    = 16'($urandom);
      b    = 16'($urandom);
      cin  = 1'($urandom);
      full = 17'(a) + 17'(b) + 17'(cin);
      s    = int'($signed(a)) + int'($signed(b)) + int'(cin);
      ovf  = (s > 32767) || (s < -32768);
      run_op(a, b, cin, lat, tr);
      vectors++;
      if (lat !== 4 || tr !== a || io.out_sum !== full[15:0] ||
          io.out_cout !== full[16]) begin
        errors++;
        $display("FAIL rand_%0d: %h+%h+%b got lat=%0d tr=%h %h/%b want 4 %h %h/%b",
                 i, a, b, cin, lat, tr, io.out_sum, io.out_cout,
                 a, full[15:0], full[16]);
      end
`ifdef DVSDCLAA_OVF_EN
      vectors++;
      if (io.out_ovf !== ovf) begin
        errors++;
        $display("FAIL rand_ovf_%0d: got %b want %b", i, io.out_ovf, ovf);
      end
`else
      if (ovf === 1'bx) $display("note: unknown ovf model value");
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drain();
    end
  endtask

`ifdef DVSDCLAA_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] ta [3] = '{16'h7FFF, 16'h8000, 16'h1234};
    logic [W-1:0] tb [3] = '{16'h0001, 16'hFFFF, 16'h4321};
    logic         eo [3] = '{1'b1, 1'b1, 1'b0};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    logic [W-1:0] tr;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, lat, tr);
      vectors++;
      if (io.out_ovf !== eo[i] || io.out_cout !== ec[i]) begin
        errors++;
        $display("FAIL ovf_%0d: got ovf=%b cout=%b want %b %b",
                 i, io.out_ovf, io.out_cout, eo[i], ec[i]);
      end
      drain();
    end
  endtask
`endif

  initial begin
    vectors      = 0;
    errors       = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_cin    = 1'b0;
    io.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_carry();
    test_backpressure();
    test_async_reset();
`ifdef DVSDCLAA_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dvsdclaa_nibble_seq.md
Name: dvsdclaa_nibble_seq

Overview:
- Sequencer that adds two wide operands by driving the team's combinational 4-bit carry-lookahead adder stage one nibble per cycle.
- Sits directly upstream of the 4-bit CLA:
  - supplies its A, B and carry-in;
  - consumes its 4-bit sum and carry-out;
  - registers the inter-nibble carry;
  - assembles the wide result behind a valid/ready handshake.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_cin  input  1  carry into least significant nibble
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  sum
out_cout  output  1  carry out of most significant nibble
busy  output  1  high in RUN or DONE
cla_a  output  4  to CLA stage A
cla_b  output  4  to CLA stage B
cla_cin  output  1  to CLA stage Cin
cla_s  input  4  from CLA stage S
cla_cout  input  1  from CLA stage Cout

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - out_sum=0; out_cout=0.
  - cla_a=0; cla_b=0; cla_cin=0.
  - All internal shift registers, carry register and counter=0.
- Outputs in_ready, out_valid and busy are decoded from the state register only. No combinational path from inputs to these outputs.
- State IDLE: in_ready=1.
  - On an edge with in_valid=1, capture in_a and in_b into shift registers a_sh and b_sh, in_cin into carry_q, and set nib_cnt=0.
  - Go to RUN.
- State RUN: in_ready=0; busy=1.
  - cla_a = a_sh[3:0], cla_b = b_sh[3:0], cla_cin = carry_q. These are combinational from registers.
  - Each edge:
    - sum_sh shifts right 4 with cla_s inserted at bits [W-1:W-4];
    - carry_q <= cla_cout;
    - a_sh and b_sh shift right 4;
    - nib_cnt++.
  - On the edge where nib_cnt==NIBBLES-1, go to DONE.
- State DONE:
  - out_valid=1; out_sum=sum_sh; out_cout=carry_q.
  - cla_* driven 0.
  - Hold all values stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- Outside RUN, cla_a, cla_b and cla_cin are 0.
- out_sum and out_cout hold their last value after DONE until the next DONE.
- Latency: operands accepted at edge T give out_valid=1 from edge T+NIBBLES. Throughput is one operation per NIBBLES+2 cycles minimum.
- No same-cycle accept: the IDLE cycle after DONE is mandatory.
- in_a and in_b may change freely after acceptance; they are not re-sampled.
- NIBBLES=1: RUN lasts exactly one cycle.
- Carry chain across nibbles is only via carry_q. The block never computes the sum itself.
- in_valid while busy is ignored (in_ready=0).
- out_ready while not out_valid has no effect.
- rst_n low in any state (mid-RUN or DONE): immediately return to reset values. The partial result is discarded and no out_valid pulse is produced.
- nib_cnt width is clog2(NIBBLES)+1. It never wraps within one operation.

Optional Feature:
Macro DVSDCLAA_OVF_EN.
- Defined: adds output port out_ovf (1 bit), the two's-complement signed overflow.
  - At acceptance, capture in_a[W-1] and in_b[W-1].
  - In DONE: out_ovf = (a_msb==b_msb) && (out_sum[W-1]!=a_msb).
  - Reset value 0; held like out_sum.
- Not defined: port and capture registers absent. Remaining behaviour is identical.

Test Plan:
(NIBBLES=4 throughout; bench models the CLA stage as a 4-bit adder.)
- 0x1234 + 0x4321, cin=0, accepted at edge T:
  - cla_a sequence 4,3,2,1;
  - out_valid at T+4, out_sum=0x5555, out_cout=0.
- 0xFFFF + 0x0001, cin=0: carry ripples through all four nibbles; out_sum=0x0000, out_cout=1.
- 0xFFFF + 0x0000, cin=1: out_sum=0x0000, out_cout=1. 0x0000 + 0x0000, cin=1: out_sum=0x0001, out_cout=0.
- Backpressure:
  - hold out_ready=0 for 3 cycles after out_valid: out_valid, out_sum and out_cout stay stable and in_ready=0;
  - out_ready=1 gives IDLE next cycle;
  - a new in_valid held high is accepted one cycle later.
- Drop rst_n asynchronously after the 2nd RUN cycle:
  - all outputs return to reset values immediately, in_ready=1;
  - no out_valid appears;
  - the next operation 0x0001 + 0x0001 returns 0x0002.
- With DVSDCLAA_OVF_EN:
  - 0x7FFF + 0x0001 gives out_ovf=1;
  - 0x8000 + 0xFFFF gives out_ovf=1, out_cout=1;
  - 0x1234 + 0x4321 gives out_ovf=0.
